// File: rtl/lifo_stack_32_bit.sv
// Eight-entry x 32-bit LIFO stack with push, pop and non-destructive peek.
// Data_Out is registered. Empty/full flags are decoded from the occupancy pointer.
module lifo_stack_32_bit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  input  logic                  Push_In,
  input  logic                  Pop_In,
  input  logic                  Peek_In,
  output logic                  LIFO_Empty,
  output logic                  LIFO_Full
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_dec;
  logic [IDX_W-1:0]      wr_idx;
  logic [IDX_W-1:0]      top_idx;

  // ptr equals occupancy; the top entry sits one below it
  assign ptr_dec    = ptr - PTR_W'(1);
  assign wr_idx     = ptr[IDX_W-1:0];
  assign top_idx    = ptr_dec[IDX_W-1:0];
  assign LIFO_Empty = (ptr == '0);
  assign LIFO_Full  = (ptr == PTR_W'(DEPTH));

  always_ff @(posedge Clk_In) begin
    if (!Reset_In) begin
      ptr      <= '0;
      Data_Out <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (Push_In) begin
      // A push while full swallows the whole cycle, including any pop
      if (!LIFO_Full) begin
        mem[wr_idx] <= Data_In;
        ptr         <= ptr + PTR_W'(1);
      end
    end else if (Pop_In) begin
      if (!LIFO_Empty) begin
        Data_Out <= mem[top_idx];
        ptr      <= ptr_dec;
      end
    end else if (Peek_In) begin
      if (!LIFO_Empty) begin
        Data_Out <= mem[top_idx];
      end
    end
  end

endmodule

// File: tb/tb_lifo_stack_32_bit.sv
// Scoreboard bench for lifo_stack_32_bit: directed scenarios then random traffic,
// checked against a queue-based stack model.
module tb_lifo_stack_32_bit;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic [31:0] dout;
  logic        push, pop, peek;
  logic        empty, full;

  lifo_stack_32_bit #(.DATA_WIDTH(32), .DEPTH(8)) dut (
    .Clk_In    (clk),
    .Reset_In  (rst_n),
    .Data_In   (din),
    .Data_Out  (dout),
    .Push_In   (push),
    .Pop_In    (pop),
    .Peek_In   (peek),
    .LIFO_Empty(empty),
    .LIFO_Full (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        e;
    logic        f;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_stack[$];
  logic [31:0] model_dout;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          stim_done = 0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every cycle's registered result is compared half a clock after the edge
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        ex = sb.pop_front();
        check_val({ex.name, ".data"},  dout,          ex.d);
        check_val({ex.name, ".empty"}, {31'b0, empty}, {31'b0, ex.e});
        check_val({ex.name, ".full"},  {31'b0, full},  {31'b0, ex.f});
      end
    end
  end

  // Reference model: plain stack semantics with push > pop > peek priority
  task automatic model_step(input logic r, input logic pu, input logic po, input logic pe,
                            input logic [31:0] d);
    if (!r) begin
      model_stack.delete();
      model_dout = 32'h0;
    end else if (pu) begin
      if (model_stack.size() < 8) model_stack.push_back(d);
    end else if (po) begin
      if (model_stack.size() > 0) model_dout = model_stack.pop_back();
    end else if (pe) begin
      if (model_stack.size() > 0) model_dout = model_stack[$];
    end
  endtask

  task automatic cycle(input string name, input logic r, input logic pu, input logic po,
                       input logic pe, input logic [31:0] d);
    exp_t ex;
    rst_n = r; push = pu; pop = po; peek = pe; din = d;
    @(posedge clk);
    model_step(r, pu, po, pe, d);
    ex.name = name;
    ex.d    = model_dout;
    ex.e    = (model_stack.size() == 0);
    ex.f    = (model_stack.size() == 8);
    sb.push_back(ex);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst_n = 1'b0; push = 0; pop = 0; peek = 0; din = '0;

    cycle("reset",        0, 0, 0, 0, 32'h0);
    cycle("peek_empty",   1, 0, 0, 1, 32'h0);
    cycle("pop_empty",    1, 0, 1, 0, 32'h0);

    for (int i = 1; i <= 8; i++) begin
      w = 32'h11111111 * i;
      cycle($sformatf("fill%0d", i), 1, 1, 0, 0, w);
    end
    cycle("push_full",    1, 1, 0, 0, 32'hDEADBEEF);
    cycle("pushpop_full", 1, 1, 1, 0, 32'hDEADBEEF);
    cycle("peek_full",    1, 0, 0, 1, 32'h0);

    for (int i = 8; i >= 1; i--) begin
      cycle($sformatf("peek%0d", i), 1, 0, 0, 1, 32'h0);
      cycle($sformatf("pop%0d", i),  1, 0, 1, 0, 32'h0);
    end
    cycle("peek_drained", 1, 0, 0, 1, 32'h0);
    cycle("pop_drained",  1, 0, 1, 0, 32'h0);

    cycle("push_a5",      1, 1, 0, 0, 32'hA5A5A5A5);
    cycle("push_5a",      1, 1, 0, 0, 32'h5A5A5A5A);
    cycle("pushpop",      1, 1, 1, 0, 32'h0000BEEF);
    cycle("pop_beef",     1, 0, 1, 0, 32'h0);
    cycle("pop_5a",       1, 0, 1, 0, 32'h0);

    cycle("pre_rst1",     1, 1, 0, 0, 32'h01020304);
    cycle("pre_rst2",     1, 1, 0, 0, 32'h05060708);
    cycle("pre_rst3",     1, 1, 0, 0, 32'h090A0B0C);
    cycle("mid_reset",    0, 1, 1, 1, 32'hFFFFFFFF);
    cycle("pop_after_rst",1, 0, 1, 0, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic r, pu, po, pe;
      r  = ($urandom_range(0, 99) >= 3);
      pu = ($urandom_range(0, 99) < 45);
      po = ($urandom_range(0, 99) < 40);
      pe = ($urandom_range(0, 99) < 30);
      cycle($sformatf("rand%0d", i), r, pu, po, pe, $urandom());
    end

    push = 0; pop = 0; peek = 0;
    stim_done = 1;
    repeat (2) @(negedge clk);
    check_val("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
